// File: rtl/sadd_pkg.sv
// Shared types and helpers for the sadd_ds digit-serial adder/subtractor.
// Holds the FSM state type, parameter range limits and the count-width function.
package sadd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DW_MIN   = 1;
  localparam int DW_MAX   = 16;
  localparam int NDIG_MIN = 2;
  localparam int NDIG_MAX = 256;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sadd_ds_if.sv
// Digit stream bundle between the serialiser, sadd_ds and the result register.
// Inputs: in_valid/first/sub/x/y. Outputs: out_valid/z/out_last/cout/ovf.
interface sadd_ds_if #(
  parameter int DW = 1
);
  logic          in_valid;
  logic          first;
  logic          sub;
  logic [DW-1:0] x;
  logic [DW-1:0] y;
  logic          out_valid;
  logic [DW-1:0] z;
  logic          out_last;
  logic          cout;
  logic          ovf;

  modport master (
    output in_valid, first, sub, x, y,
    input  out_valid, z, out_last, cout, ovf
  );

  modport slave (
    input  in_valid, first, sub, x, y,
    output out_valid, z, out_last, cout, ovf
  );
endinterface

// File: rtl/sadd_digit_cell.sv
// Combinational DW-bit digit adder; inv complements y for subtraction.
// In: x, y, cin, inv. Out: s (sum digit), c (carry), ovf_digit (signed ovf).
module sadd_digit_cell #(
  parameter int DW = 1
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic          cin,
  input  logic          inv,
  output logic [DW-1:0] s,
  output logic          c,
  output logic          ovf_digit
);
  logic [DW-1:0] w_yb;

  assign w_yb = inv ? ~y : y;
  assign {c, s} = {1'b0, x} + {1'b0, w_yb} + {{DW{1'b0}}, cin};
  assign ovf_digit = (x[DW-1] == w_yb[DW-1]) &
                     (s[DW-1] != x[DW-1]);
endmodule

// File: rtl/sadd_ds.sv
// Digit-serial add/sub, LSB digit first, DW bits per cycle, NDIG digits/word.
// Ports: clk, rst (sync, active-high), bus (sadd_ds_if.slave).
module sadd_ds
  import sadd_pkg::*;
#(
  parameter int DW   = 1,
  parameter int NDIG = 8
) (
  input  logic    clk,
  input  logic    rst,
  sadd_ds_if.slave bus
);
  localparam int CW = clog2(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (DW < DW_MIN || DW > DW_MAX ||
      NDIG < NDIG_MIN || NDIG > NDIG_MAX) begin : g_bad_param
    $error("sadd_ds: DW or NDIG out of range");
  end

  state_t        r_state;
  logic          r_carry;
  logic          r_mode;
  logic [CW-1:0] r_cnt;
  logic          r_out_valid;
  logic [DW-1:0] r_z;
  logic          r_last;
  logic          r_cout;
  logic          r_ovf;

  logic          w_start;
  logic          w_cin;
  logic          w_mode;
  logic [DW-1:0] w_s;
  logic          w_c;
  logic          w_ovf;

  // A first digit restarts the word in any state, so the
  // cell sees the incoming mode/carry-in rather than stored ones.
  assign w_start = bus.in_valid & bus.first;
  assign w_cin   = w_start ? bus.sub : r_carry;
  assign w_mode  = w_start ? bus.sub : r_mode;

  sadd_digit_cell #(.DW(DW)) u_cell (
    .x         (bus.x),
    .y         (bus.y),
    .cin       (w_cin),
    .inv       (w_mode),
    .s         (w_s),
    .c         (w_c),
    .ovf_digit (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_carry     <= 1'b0;
      r_mode      <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_z         <= '0;
      r_last      <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      if (w_start) begin
        // NDIG >= 2, so a first digit is never also the last.
        r_mode      <= bus.sub;
        r_carry     <= w_c;
        r_z         <= w_s;
        r_out_valid <= 1'b1;
        r_cnt       <= CW'(1);
        r_state     <= RUN;
      end else if (bus.in_valid) begin
        unique case (r_state)
          IDLE: ;
          RUN: begin
            r_carry     <= w_c;
            r_z         <= w_s;
            r_out_valid <= 1'b1;
            if (r_cnt == LAST) begin
              r_last  <= 1'b1;
              r_cout  <= w_c;
              r_ovf   <= w_ovf;
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.z         = r_z;
  assign bus.out_last  = r_last;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_sadd_ds.sv
// Directed bench for sadd_ds: two instances (DW=1/NDIG=4, DW=4/NDIG=2).
// Hand-computed digit streams, abort, reset and idle-noise cases.
module tb_sadd_ds;
  import sadd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sadd_ds_if #(.DW(1)) ifc1 ();
  sadd_ds_if #(.DW(4)) ifc4 ();

  sadd_ds #(.DW(1), .NDIG(4)) u_d1 (
    .clk (clk),
    .rst (rst),
    .bus (ifc1.slave)
  );

  sadd_ds #(.DW(4), .NDIG(2)) u_d4 (
    .clk (clk),
    .rst (rst),
    .bus (ifc4.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc1.in_valid = 1'b0;
    ifc4.in_valid = 1'b0;
    tick();
  endtask

  task automatic d1_dig(input string tag,
                        input bit f, input bit sb,
                        input bit xv, input bit yv,
                        input bit ez, input bit el,
                        input bit ec, input bit eo);
    ifc1.in_valid = 1'b1;
    ifc1.first    = f;
    ifc1.sub      = sb;
    ifc1.x        = xv;
    ifc1.y        = yv;
    tick();
    chk({tag, ".v"}, 32'(ifc1.out_valid), 32'd1);
    chk({tag, ".z"}, 32'(ifc1.z), 32'(ez));
    chk({tag, ".l"}, 32'(ifc1.out_last), 32'(el));
    chk({tag, ".c"}, 32'(ifc1.cout), 32'(ec));
    chk({tag, ".o"}, 32'(ifc1.ovf), 32'(eo));
  endtask

  task automatic d4_dig(input string tag,
                        input bit f, input bit sb,
                        input logic [3:0] xv,
                        input logic [3:0] yv,
                        input logic [3:0] ez, input bit el,
                        input bit ec, input bit eo);
    ifc4.in_valid = 1'b1;
    ifc4.first    = f;
    ifc4.sub      = sb;
    ifc4.x        = xv;
    ifc4.y        = yv;
    tick();
    chk({tag, ".v"}, 32'(ifc4.out_valid), 32'd1);
    chk({tag, ".z"}, 32'(ifc4.z), 32'(ez));
    chk({tag, ".l"}, 32'(ifc4.out_last), 32'(el));
    chk({tag, ".c"}, 32'(ifc4.cout), 32'(ec));
    chk({tag, ".o"}, 32'(ifc4.ovf), 32'(eo));
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, ".v"}, 32'(ifc1.out_valid), 32'd0);
    chk({tag, ".z"}, 32'(ifc1.z), 32'd0);
    chk({tag, ".l"}, 32'(ifc1.out_last), 32'd0);
    chk({tag, ".c"}, 32'(ifc1.cout), 32'd0);
    chk({tag, ".o"}, 32'(ifc1.ovf), 32'd0);
  endtask

  initial begin
    ifc1.in_valid = 1'b1;
    ifc1.first    = 1'b1;
    ifc1.sub      = 1'b0;
    ifc1.x        = '1;
    ifc1.y        = '1;
    ifc4.in_valid = 1'b1;
    ifc4.first    = 1'b1;
    ifc4.sub      = 1'b0;
    ifc4.x        = '1;
    ifc4.y        = '1;
    rst = 1'b1;
    tick();
    tick();
    chk_zero1("rst1");
    chk("rst4.v", 32'(ifc4.out_valid), 32'd0);
    chk("rst4.z", 32'(ifc4.z), 32'd0);
    chk("rst1.st", 32'(u_d1.r_state), 32'(IDLE));
    rst = 1'b0;
    idle();

    // 3 + 5 = 8, signed overflow in 4 bits
    d1_dig("add0", 1, 0, 1, 1, 0, 0, 0, 0);
    d1_dig("add1", 0, 0, 1, 0, 0, 0, 0, 0);
    d1_dig("add2", 0, 0, 0, 1, 0, 0, 0, 0);
    d1_dig("add3", 0, 0, 0, 0, 1, 1, 0, 1);
    // 5 - 3 = 2 then 3 - 5 = -2, back to back
    d1_dig("subA0", 1, 1, 1, 1, 0, 0, 0, 0);
    d1_dig("subA1", 0, 0, 0, 1, 1, 0, 0, 0);
    d1_dig("subA2", 0, 0, 1, 0, 0, 0, 0, 0);
    d1_dig("subA3", 0, 0, 0, 0, 0, 1, 1, 0);
    d1_dig("subB0", 1, 1, 1, 1, 0, 0, 0, 0);
    d1_dig("subB1", 0, 0, 1, 0, 1, 0, 0, 0);
    d1_dig("subB2", 0, 0, 0, 1, 1, 0, 0, 0);
    d1_dig("subB3", 0, 0, 0, 0, 1, 1, 0, 0);
    idle();
    chk("post.v", 32'(ifc1.out_valid), 32'd0);

    // 0x7F + 0x01, then 0xFF + 0x01 with no gap
    d4_dig("h7f0", 1, 0, 4'hF, 4'h1, 4'h0, 0, 0, 0);
    d4_dig("h7f1", 0, 0, 4'h7, 4'h0, 4'h8, 1, 0, 1);
    d4_dig("hff0", 1, 0, 4'hF, 4'h1, 4'h0, 0, 0, 0);
    d4_dig("hff1", 0, 0, 4'hF, 4'h0, 4'h0, 1, 1, 0);

    // 0x12 + 0x34 with a 3-cycle gap between digits
    d4_dig("gap0", 1, 0, 4'h2, 4'h4, 4'h6, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("gap.v", 32'(ifc4.out_valid), 32'd0);
    end
    d4_dig("gap1", 0, 0, 4'h1, 4'h3, 4'h4, 1, 0, 0);
    idle();

    // Abort after 2 digits, new word 5 - 3
    d1_dig("ab0", 1, 0, 1, 1, 0, 0, 0, 0);
    d1_dig("ab1", 0, 0, 1, 0, 0, 0, 0, 0);
    d1_dig("abS0", 1, 1, 1, 1, 0, 0, 0, 0);
    d1_dig("abS1", 0, 0, 0, 1, 1, 0, 0, 0);
    d1_dig("abS2", 0, 0, 1, 0, 0, 0, 0, 0);
    d1_dig("abS3", 0, 0, 0, 0, 0, 1, 1, 0);
    idle();

    // Reset mid-word, with in_valid also high
    d1_dig("rw0", 1, 0, 1, 0, 1, 0, 0, 0);
    d1_dig("rw1", 0, 0, 1, 1, 0, 0, 0, 0);
    rst = 1'b1;
    ifc1.in_valid = 1'b1;
    ifc1.first    = 1'b0;
    tick();
    chk_zero1("rmid");
    chk("rmid.st", 32'(u_d1.r_state), 32'(IDLE));
    rst = 1'b0;
    d1_dig("rn0", 1, 0, 1, 1, 0, 0, 0, 0);
    d1_dig("rn1", 0, 0, 1, 0, 0, 0, 0, 0);
    d1_dig("rn2", 0, 0, 0, 1, 0, 0, 0, 0);
    d1_dig("rn3", 0, 0, 0, 0, 1, 1, 0, 1);

    // Non-first digits while idle are dropped
    ifc1.in_valid = 1'b1;
    ifc1.first    = 1'b0;
    ifc1.x        = 1'b1;
    ifc1.y        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nf.v", 32'(ifc1.out_valid), 32'd0);
      chk("nf.st", 32'(u_d1.r_state), 32'(IDLE));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
